// File: rtl/ctx_mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctx_mem_arb_pkg
// Purpose  : Shared types and constants for the ctx/core data-memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ctx_mem_arb_pkg;

  // Owner tag carried through the owner queue so that each response can be
  // steered back to the master that issued the request.
  typedef enum logic [1:0] {
    OWN_CORE   = 2'd0,
    OWN_CTX_WR = 2'd1,
    OWN_CTX_RD = 2'd2
  } owner_e;

  localparam int OWNER_W = 2;

  // Context save/restore always moves whole words.
  localparam logic [3:0] CTX_BE_FULL = 4'hF;

endpackage
`default_nettype wire

// File: rtl/ctx_mem_owner_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ctx_mem_owner_fifo
// Purpose  : Small synchronous FIFO holding the owner tag of every issued,
//            not yet answered memory transaction.
// Revision : 1.0 - initial release
// ============================================================================
module ctx_mem_owner_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign full_o  = (r_count == C_DEPTH);
  assign empty_o = (r_count == '0);
  assign head_o  = r_mem[r_rd_ptr];

  // Overflow and underflow requests are dropped rather than corrupting state.
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i & ~empty_o;

  // Storage, pointers (wrapping modulo DEPTH) and occupancy count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data_i;
        r_wr_ptr        <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ctx_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ctx_mem_bus_arbiter
// Purpose  : Shares one OBI data-memory port between the core LSU and the
//            RTOS context save/restore channels, with a stall-stable locked
//            grant, bounded ctx starvation and in-order response routing.
// Revision : 1.0 - initial release
// ============================================================================
module ctx_mem_bus_arbiter
  import ctx_mem_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING  = 2,
  parameter int CTX_STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // core LSU
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  // ctx save channel
  input  logic        ctx_wr_valid_i,
  output logic        ctx_wr_ready_o,
  input  logic [31:0] ctx_wr_addr_i,
  input  logic [31:0] ctx_wr_data_i,
  // ctx restore channel
  input  logic        ctx_rd_valid_i,
  output logic        ctx_rd_ready_o,
  input  logic [31:0] ctx_rd_addr_i,
  output logic        ctx_rd_resp_valid_o,
  output logic [31:0] ctx_rd_data_o,
  // memory side
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int STARVE_W = $clog2(CTX_STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] C_STARVE_LIMIT = STARVE_W'(CTX_STARVE_LIMIT);

  logic                r_lock;
  owner_e              r_lock_src;
  logic [STARVE_W-1:0] r_starve_cnt;

  owner_e              w_sel;
  logic                w_sel_valid;
  logic                w_ctx_pend;
  logic                w_grant;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [OWNER_W-1:0]  w_fifo_head;
  owner_e              w_head_owner;
  logic                w_pop;

  assign w_ctx_pend = ctx_wr_valid_i | ctx_rd_valid_i;

  // Source selection: a stalled request keeps the bus; otherwise a starved
  // ctx request is forced once, else core > ctx_wr > ctx_rd.
  always_comb begin
    w_sel       = OWN_CORE;
    w_sel_valid = 1'b0;
    if (r_lock) begin
      w_sel = r_lock_src;
      case (r_lock_src)
        OWN_CORE:   w_sel_valid = core_req_i;
        OWN_CTX_WR: w_sel_valid = ctx_wr_valid_i;
        OWN_CTX_RD: w_sel_valid = ctx_rd_valid_i;
        default:    w_sel_valid = 1'b0;
      endcase
    end else if ((r_starve_cnt == C_STARVE_LIMIT) && w_ctx_pend) begin
      w_sel       = ctx_wr_valid_i ? OWN_CTX_WR : OWN_CTX_RD;
      w_sel_valid = 1'b1;
    end else if (core_req_i) begin
      w_sel       = OWN_CORE;
      w_sel_valid = 1'b1;
    end else if (ctx_wr_valid_i) begin
      w_sel       = OWN_CTX_WR;
      w_sel_valid = 1'b1;
    end else if (ctx_rd_valid_i) begin
      w_sel       = OWN_CTX_RD;
      w_sel_valid = 1'b1;
    end
  end

  // A full owner queue blocks issue even when a response pops this cycle,
  // so the request path never depends on mem_rvalid_i.
  assign mem_req_o = w_sel_valid & ~w_fifo_full & ~rst_i;
  assign w_grant   = mem_req_o & mem_gnt_i;

  assign core_gnt_o     = w_grant & (w_sel == OWN_CORE);
  assign ctx_wr_ready_o = w_grant & (w_sel == OWN_CTX_WR);
  assign ctx_rd_ready_o = w_grant & (w_sel == OWN_CTX_RD);

  // Request mux; idle bus is driven to zero.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    if (mem_req_o) begin
      case (w_sel)
        OWN_CORE: begin
          mem_we_o    = core_we_i;
          mem_be_o    = core_be_i;
          mem_addr_o  = core_addr_i;
          mem_wdata_o = core_wdata_i;
        end
        OWN_CTX_WR: begin
          mem_we_o    = 1'b1;
          mem_be_o    = CTX_BE_FULL;
          mem_addr_o  = ctx_wr_addr_i;
          mem_wdata_o = ctx_wr_data_i;
        end
        OWN_CTX_RD: begin
          mem_we_o    = 1'b0;
          mem_be_o    = CTX_BE_FULL;
          mem_addr_o  = ctx_rd_addr_i;
          mem_wdata_o = 32'h0;
        end
        default: begin
          mem_we_o    = 1'b0;
        end
      endcase
    end
  end

  // Lock follows a stalled request; any grant or dropped request releases it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lock     <= 1'b0;
      r_lock_src <= OWN_CORE;
    end else if (mem_req_o && !mem_gnt_i) begin
      r_lock     <= 1'b1;
      r_lock_src <= w_sel;
    end else begin
      r_lock     <= 1'b0;
    end
  end

  // Count core grants taken while ctx waits, saturating at the limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (!w_ctx_pend || ctx_wr_ready_o || ctx_rd_ready_o) begin
      r_starve_cnt <= '0;
    end else if (core_gnt_o && (r_starve_cnt != C_STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  ctx_mem_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (OWNER_W)
  ) u_owner_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (w_grant),
    .push_data_i (w_sel),
    .pop_i       (w_pop),
    .full_o      (w_fifo_full),
    .empty_o     (w_fifo_empty),
    .head_o      (w_fifo_head)
  );

  assign w_head_owner = owner_e'(w_fifo_head);

  // A response with nothing outstanding is ignored (no pop, no pulse).
  assign w_pop = mem_rvalid_i & ~w_fifo_empty & ~rst_i;

  assign core_rvalid_o       = w_pop & (w_head_owner == OWN_CORE);
  assign ctx_rd_resp_valid_o = w_pop & (w_head_owner == OWN_CTX_RD);
  assign core_rdata_o        = mem_rdata_i;
  assign ctx_rd_data_o       = mem_rdata_i;

  // Flag responses that arrive with no outstanding transaction.
  always @(posedge clk_i) begin
    if (!rst_i && mem_rvalid_i) begin
      assert (!w_fifo_empty)
        else $warning("ctx_mem_bus_arbiter: rvalid with no outstanding transaction, ignored");
    end
  end

endmodule
`default_nettype wire

// File: doc/ctx_mem_bus_arbiter.md
Name: ctx_mem_bus_arbiter

Overview:
Shares one OBI-style data memory port between two masters: the core LSU data port and the RTOS unit context-save/restore channels (ctx write, ctx read request, ctx read response).
Replaces the fixed core-first combinational gating with the following:
- a locked grant that stays stable across memory stalls;
- starvation-bounded priority;
- an in-order owner queue that routes each memory response back to the master that issued it.
It sits between cv32e40p_top/mkRTOSUnitSynth and the memory model or interconnect.

Parameters:
MAX_OUTSTANDING, 2, depth of the owner queue (maximum issued but unanswered transactions); power of two, ≥1.
CTX_STARVE_LIMIT, 4, number of consecutive core grants allowed while a ctx request waits before ctx is forced once; ≥1.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
core_req_i  in  1  core data request (OBI)
core_gnt_o  out  1  core grant
core_we_i  in  1  core write enable
core_be_i  in  4  core byte enables
core_addr_i  in  32  core address
core_wdata_i  in  32  core write data
core_rvalid_o  out  1  core response valid
core_rdata_o  out  32  core read data
ctx_wr_valid_i  in  1  ctx write request
ctx_wr_ready_o  out  1  ctx write accepted
ctx_wr_addr_i  in  32  ctx write address
ctx_wr_data_i  in  32  ctx write data
ctx_rd_valid_i  in  1  ctx read request
ctx_rd_ready_o  out  1  ctx read accepted
ctx_rd_addr_i  in  32  ctx read address
ctx_rd_resp_valid_o  out  1  ctx read data valid
ctx_rd_data_o  out  32  ctx read data
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_we_o  out  1  memory write enable
mem_be_o  out  4  memory byte enables
mem_addr_o  out  32  memory address
mem_wdata_o  out  32  memory write data
mem_rvalid_i  in  1  memory response valid
mem_rdata_i  in  32  memory read data

Behaviour:
Reset:
- On rst_i: all outputs 0; owner queue emptied; lock cleared; starve counter 0.
- Reset asserted mid-transaction drops all in-flight responses. No rvalid is forwarded until a new grant occurs after reset release.

Issue (zero-latency, combinational request path):
- mem_req_o = (selected source valid) AND NOT queue_full.
- The grant to a source equals mem_gnt_i AND that source is selected.
- Ctx writes drive we=1, be=4'hF. Ctx reads drive we=0, be=4'hF.

Selection:
- If the lock is held, the locked source is selected.
- Otherwise, if starve_cnt == CTX_STARVE_LIMIT and a ctx request is pending, ctx is selected.
- Otherwise priority is core > ctx_wr > ctx_rd.
- ctx_wr beats ctx_rd so that saves complete before restores.

Lock:
- Set when mem_req_o=1 and mem_gnt_i=0; records the selected source.
- Cleared on grant.
- While locked, the other sources see gnt/ready = 0 and the mux is frozen.

Starve counter:
- Increments on a core grant while any ctx valid is high, saturating at the limit.
- Cleared on any ctx grant, or in any cycle with no ctx valid.

Owner queue:
- Each granted transaction pushes its owner (CORE, CTX_WR, CTX_RD).
- Each mem_rvalid_i pops the head.
- Routing of the popped response:
  - CORE: core_rvalid_o=1, core_rdata_o=mem_rdata_i.
  - CTX_RD: ctx_rd_resp_valid_o=1, ctx_rd_data_o=mem_rdata_i.
  - CTX_WR: response absorbed, nothing forwarded.
- rdata outputs carry mem_rdata_i unconditionally; qualify them only by valid.

Queue boundaries:
- Push and pop in the same cycle are legal at any occupancy and leave the count unchanged.
- When full: mem_req_o is held 0 and no new grants are given, even if a pop happens in the same cycle. This keeps the request path independent of rvalid.
- mem_rvalid_i with an empty queue is a protocol error: flag it with a simulation assertion and ignore it; no output pulses.
- The counter width is clog2(MAX_OUTSTANDING)+1, and pointers wrap modulo the depth.

Decomposition:
- Package ctx_mem_arb_pkg holds the owner enum (OWN_CORE, OWN_CTX_WR, OWN_CTX_RD, 2 bits) and CTX_BE_FULL = 4'hF.
- Sub-module ctx_mem_owner_fifo (parameterised depth) provides a synchronous FIFO with push, pop, full, empty and head outputs, using asynchronous active-high reset.
- Arbitration, lock and starve logic stay in the top.

Test Plan:
- Core-only traffic: core read to 0x100 with gnt at the same cycle, rvalid 1 cycle later with rdata 0xDEADBEEF → core_rvalid_o=1, core_rdata_o=0xDEADBEEF; ctx outputs stay 0.
- Starvation: core_req_i held 1 continuously with ctx_rd_valid_i=1 and LIMIT=4 → 4 core grants, then ctx_rd_ready_o=1 on the 5th, then the core resumes.
- Lock: ctx_wr to 0x2000 with mem_gnt_i low for 3 cycles while core_req_i rises → mem_addr_o stays 0x2000 and core_gnt_o=0 until the ctx grant.
- Mixed responses: grant sequence CTX_WR, CORE (depth 2) → first rvalid absorbed; second gives core_rvalid_o=1.
- Queue full: depth 2, two grants without rvalid → mem_req_o=0 despite pending requests. One rvalid → mem_req_o returns the next cycle.
- Reset mid-flight: two outstanding transactions, pulse rst_i, then 2 stray rvalids → no core or ctx valid outputs; the assertion fires.
